// File: rtl/iter_shift_ctrl.sv
// Iterative SLL/SRL/SRA controller: one request at a time, shamt shift edges, done pulse.
// Optional FAST_SHIFT4_EN: shift by 4 per edge while the remaining count is >= 4.
module iter_shift_ctrl #(
    parameter  int N  = 32,
    localparam int SW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          kill,
    input  logic [1:0]    op,
    input  logic [N-1:0]  data_in,
    input  logic [SW-1:0] shamt,
    output logic          ready,
    output logic          busy,
    output logic          done,
    output logic [N-1:0]  result
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRA = 2'b11;

    state_t        state_q, state_d;
    logic [N-1:0]  sreg_q, sreg_d;
    logic [SW-1:0] cnt_q, cnt_d;
    logic [1:0]    op_q, op_d;
    logic          ready_q, ready_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic          accept;
    logic          fill;
    logic          big_step;
    logic [N-1:0]  sh1;
    logic [N-1:0]  sh4;

    // Fill bit is the sign only for SRA; SRL and the reserved code shift in zeros.
    always_comb begin
        fill = (op_q == OP_SRA) & sreg_q[N-1];
        sh1  = {fill, sreg_q[N-1:1]};
        sh4  = {{4{fill}}, sreg_q[N-1:4]};
        unique case (1'b1)
            (op_q == OP_SLL): begin
                sh1 = {sreg_q[N-2:0], 1'b0};
                sh4 = {sreg_q[N-5:0], 4'b0000};
            end
            default: begin
                sh1 = {fill, sreg_q[N-1:1]};
                sh4 = {{4{fill}}, sreg_q[N-1:4]};
            end
        endcase
    end

`ifdef FAST_SHIFT4_EN
    logic [SW:0] cnt_ext;
    always_comb begin
        cnt_ext  = {1'b0, cnt_q};
        big_step = (cnt_ext >= (SW+1)'(4));
    end
`else
    always_comb begin
        big_step = 1'b0;
    end
`endif

    // kill outranks start in every state, so a killed start is never accepted.
    assign accept = start & ~kill & (state_q != SHIFT);

    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (accept) begin
                    sreg_d  = data_in;
                    cnt_d   = shamt;
                    op_d    = op;
                    state_d = (shamt == '0) ? DONE : SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                if (kill) begin
                    state_d = IDLE;
                end else if (big_step) begin
                    sreg_d  = sh4;
                    cnt_d   = cnt_q - SW'(4);
                    state_d = (cnt_q == SW'(4)) ? DONE : SHIFT;
                end else begin
                    sreg_d  = sh1;
                    cnt_d   = cnt_q - SW'(1);
                    state_d = (cnt_q == SW'(1)) ? DONE : SHIFT;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        ready_d = (state_d != SHIFT);
        busy_d  = (state_d == SHIFT);
        done_d  = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sreg_q  <= '0;
            cnt_q   <= '0;
            op_q    <= 2'b00;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign ready  = ready_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign result = sreg_q;

endmodule

// File: tb/tb_iter_shift_ctrl.sv
// Bench for iter_shift_ctrl: vector table, corner sequences, random vs reference model.
module tb_iter_shift_ctrl;

`ifdef FAST_SHIFT4_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        kill;
    logic [1:0]  op;
    logic [31:0] data_in;
    logic [4:0]  shamt;
    logic        ready;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int n_cmp;
    int n_bad;

    iter_shift_ctrl #(.N(32)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .kill    (kill),
        .op      (op),
        .data_in (data_in),
        .shamt   (shamt),
        .ready   (ready),
        .busy    (busy),
        .done    (done),
        .result  (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] d;
        logic [4:0]  s;
        logic [31:0] res;
        int          lat;
    } vec_t;

    vec_t vt[7];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_res(input logic [1:0] o,
                                            input logic [31:0] d,
                                            input int s);
        logic signed [31:0] sd;
        sd = $signed(d);
        if (o == 2'b00) return d << s;
        if (o == 2'b11) return 32'(sd >>> s);
        return d >> s;
    endfunction

    function automatic int ref_lat(input int s);
        if (s == 0) return 1;
        if (FAST) return s / 4 + s % 4 + 1;
        return s + 1;
    endfunction

    // Issue a request, wait (bounded) for done; optionally poke ignored starts.
    task automatic run_op(input logic [1:0] o, input logic [31:0] d,
                          input logic [4:0] s, input bit noise,
                          output int lat, output int bc,
                          output logic [31:0] res);
        op      = o;
        data_in = d;
        shamt   = s;
        start   = 1'b1;
        tick();
        start = 1'b0;
        lat   = 1;
        bc    = 0;
        while (!done && lat < 100) begin
            if (busy) bc++;
            if (noise && busy) begin
                start   = 1'b1;
                op      = 2'($urandom);
                data_in = 32'h0000_1234;
                shamt   = 5'($urandom);
            end
            tick();
            start = 1'b0;
            lat++;
        end
        res = result;
    endtask

    task automatic chk_idle(input string name);
        chk({name, "_ready"}, 32'(ready), 32'd1);
        chk({name, "_busy"}, 32'(busy), 32'd0);
        chk({name, "_done"}, 32'(done), 32'd0);
    endtask

    initial begin
        int lat, bc, seen;
        logic [31:0] res;
        n_cmp   = 0;
        n_bad   = 0;
        rst_n   = 1'b0;
        start   = 1'b0;
        kill    = 1'b0;
        op      = 2'b00;
        data_in = '0;
        shamt   = '0;

        vt[0] = '{2'b00, 32'h0000_0001, 5'd5,  32'h0000_0020, FAST ? 3 : 6};
        vt[1] = '{2'b11, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, FAST ? 11 : 32};
        vt[2] = '{2'b01, 32'h8000_0000, 5'd31, 32'h0000_0001, FAST ? 11 : 32};
        vt[3] = '{2'b00, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF, 1};
        vt[4] = '{2'b10, 32'h0000_00F0, 5'd4,  32'h0000_000F, FAST ? 2 : 5};
        vt[5] = '{2'b11, 32'h7000_0000, 5'd4,  32'h0700_0000, FAST ? 2 : 5};
        vt[6] = '{2'b01, 32'hFFFF_FFFF, 5'd8,  32'h00FF_FFFF, FAST ? 3 : 9};

        #12;
        chk_idle("reset");
        chk("reset_result", result, 32'h0);
        rst_n = 1'b1;
        tick();
        chk_idle("post_reset");

        for (int i = 0; i < 7; i++) begin
            run_op(vt[i].op, vt[i].d, vt[i].s, 1'b0, lat, bc, res);
            chk($sformatf("vec%0d_result", i), res, vt[i].res);
            chk($sformatf("vec%0d_lat", i), 32'(lat), 32'(vt[i].lat));
            chk($sformatf("vec%0d_busy", i), 32'(bc), 32'(vt[i].lat - 1));
            tick();
            chk_idle($sformatf("vec%0d_after", i));
            chk($sformatf("vec%0d_hold", i), result, vt[i].res);
        end

        // Ignored start during SHIFT, then back-to-back accept in DONE.
        run_op(2'b00, 32'h0000_0001, 5'd3, 1'b1, lat, bc, res);
        chk("b2b_first_result", res, 32'h0000_0008);
        chk("b2b_first_lat", 32'(lat), 32'(ref_lat(3)));
        run_op(2'b01, 32'h0000_0100, 5'd2, 1'b0, lat, bc, res);
        chk("b2b_second_result", res, 32'h0000_0040);
        chk("b2b_second_lat", 32'(lat), 32'd3);
        chk("b2b_second_busy", 32'(bc), 32'd2);
        tick();
        chk_idle("b2b_after");

        // Back-to-back shamt=0 requests give consecutive done cycles.
        run_op(2'b00, 32'h0000_00AA, 5'd0, 1'b0, lat, bc, res);
        chk("z2z_first", res, 32'h0000_00AA);
        run_op(2'b00, 32'h0000_00BB, 5'd0, 1'b0, lat, bc, res);
        chk("z2z_second", res, 32'h0000_00BB);
        chk("z2z_lat", 32'(lat), 32'd1);
        tick();

        // kill on the 2nd SHIFT cycle.
        op      = 2'b00;
        data_in = 32'h0000_0003;
        shamt   = 5'd10;
        start   = 1'b1;
        tick();
        start = 1'b0;
        chk("kill_busy1", 32'(busy), 32'd1);
        tick();
        chk("kill_busy2", 32'(busy), 32'd1);
        kill = 1'b1;
        tick();
        kill = 1'b0;
        chk_idle("kill_next");
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done) seen++;
        end
        chk("kill_no_done", 32'(seen), 32'd0);

        // kill with start in IDLE drops the start.
        start   = 1'b1;
        kill    = 1'b1;
        shamt   = 5'd3;
        tick();
        start = 1'b0;
        kill  = 1'b0;
        chk_idle("kill_start_idle");

        // Asynchronous reset between edges during SHIFT.
        op      = 2'b00;
        data_in = 32'h0000_00FF;
        shamt   = 5'd10;
        start   = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("areset_pre_busy", 32'(busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_idle("areset");
        chk("areset_result", result, 32'h0);
        rst_n = 1'b1;
        tick();
        run_op(2'b01, 32'h0000_00F0, 5'd4, 1'b0, lat, bc, res);
        chk("areset_after_result", res, 32'h0000_000F);
        chk("areset_after_lat", 32'(lat), 32'(ref_lat(4)));
        tick();

        // Randomized requests against the reference model.
        for (int i = 0; i < 40; i++) begin
            logic [1:0]  ro;
            logic [31:0] rd;
            logic [4:0]  rs;
            ro = 2'($urandom);
            rd = $urandom;
            rs = 5'($urandom);
            run_op(ro, rd, rs, 1'($urandom), lat, bc, res);
            chk($sformatf("rnd%0d_result", i), res, ref_res(ro, rd, int'(rs)));
            chk($sformatf("rnd%0d_lat", i), 32'(lat), 32'(ref_lat(int'(rs))));
            chk($sformatf("rnd%0d_busy", i), 32'(bc), 32'(ref_lat(int'(rs)) - 1));
            if (($urandom % 2) == 0) tick();
        end
        tick();
        chk_idle("final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
